// File: rtl/crc_seg_pkg.sv
// Shared types and helpers for the CRC segment splitter: walk-state enum,
// tag/zero-count widths and the zero-byte distance calculation.
package crc_seg_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } walk_state_t;

    localparam int SEG_BYTES  = 8;
    localparam int PKT_NUM_W  = 4;
    localparam int ZERO_NUM_W = 12;

    // Bytes from the eop inside segment k to the end of the beat.
    function automatic logic [ZERO_NUM_W-1:0] zero_num(
        input int                    k,
        input logic [ZERO_NUM_W-1:0] empty,
        input int                    seg_num,
        input int                    seg_bytes
    );
        return empty + ZERO_NUM_W'((seg_num - 1 - k) * seg_bytes);
    endfunction

endpackage

// File: rtl/crc_seg_classify.sv
// One combinational step of the segment walk: takes the packet state entering
// a segment and classifies that segment, producing the state leaving it.
module crc_seg_classify
    import crc_seg_pkg::*;
(
    input  logic state_i,
    input  logic sop_i,
    input  logic eop_i,
    output logic state_o,
    output logic sop_o,
    output logic eop_o,
    output logic dval_o,
    output logic inc_o,
    output logic err_sop_o,
    output logic err_eop_o
);

    walk_state_t state_in;
    walk_state_t state_out;

    assign state_in = walk_state_t'(state_i);
    assign state_o  = logic'(state_out);

    always_comb begin
        state_out = state_in;
        sop_o     = 1'b0;
        eop_o     = 1'b0;
        dval_o    = 1'b0;
        inc_o     = 1'b0;
        err_sop_o = 1'b0;
        err_eop_o = 1'b0;
        if (sop_i) begin
            // A sop inside an open packet abandons it and restarts cleanly.
            err_sop_o = (state_in == IN_PKT);
            dval_o    = 1'b1;
            sop_o     = 1'b1;
            inc_o     = 1'b1;
            eop_o     = eop_i;
            state_out = eop_i ? IDLE : IN_PKT;
        end else if (state_in == IN_PKT) begin
            dval_o = 1'b1;
            eop_o  = eop_i;
            if (eop_i) begin
                state_out = IDLE;
            end
        end else if (eop_i) begin
            err_eop_o = 1'b1;
        end
    end

endmodule

// File: rtl/crc_seg_splitter.sv
// Two-stage ingress splitter that tags each beat segment with sop/eop/dval,
// packet number and zero-byte count. Optional macro: CRC_SEG_PAD_ZERO_EN.
module crc_seg_splitter
    import crc_seg_pkg::*;
#(
    parameter int SEG_NUM   = 4,
    parameter int BUS_WIDTH = 64,
    parameter int EMPTY_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [SEG_NUM-1:0]              in_sop,
    input  logic [SEG_NUM-1:0]              in_eop,
    input  logic [SEG_NUM*EMPTY_W-1:0]      in_empty,
    input  logic [SEG_NUM*BUS_WIDTH-1:0]    in_data,
    output logic [SEG_NUM-1:0]              seg_sop,
    output logic [SEG_NUM-1:0]              seg_eop,
    output logic [SEG_NUM-1:0]              seg_dval,
    output logic [SEG_NUM*PKT_NUM_W-1:0]    seg_packet_num,
    output logic [SEG_NUM*ZERO_NUM_W-1:0]   seg_zero_num,
    output logic [SEG_NUM*BUS_WIDTH-1:0]    seg_dout,
    output logic                            err_sop,
    output logic                            err_eop
);

    localparam int SEG_B = BUS_WIDTH / 8;

    logic                          s1_valid_q;
    logic [SEG_NUM-1:0]            s1_sop_q, s1_eop_q;
    logic [SEG_NUM*EMPTY_W-1:0]    s1_empty_q;
    logic [SEG_NUM*BUS_WIDTH-1:0]  s1_data_q;

    walk_state_t                   state_q;
    logic [PKT_NUM_W-1:0]          cnt_q, cur_q;

    logic [SEG_NUM-1:0]            seg_sop_q, seg_eop_q, seg_dval_q;
    logic [SEG_NUM*PKT_NUM_W-1:0]  seg_packet_num_q;
    logic [SEG_NUM*ZERO_NUM_W-1:0] seg_zero_num_q;
    logic [SEG_NUM*BUS_WIDTH-1:0]  seg_dout_q;
    logic                          err_sop_q, err_eop_q;

    // Walk chain: entry gi is the state entering segment gi.
    logic                          st_c  [SEG_NUM+1];
    logic [PKT_NUM_W-1:0]          cnt_c [SEG_NUM+1];
    logic [PKT_NUM_W-1:0]          cur_c [SEG_NUM+1];
    logic [SEG_NUM-1:0]            sop_c, eop_c, dval_c, inc_c, es_c, ee_c, dval_v;
    logic [SEG_NUM*PKT_NUM_W-1:0]  tag_d;
    logic [SEG_NUM*ZERO_NUM_W-1:0] zero_d;
    logic [SEG_NUM*BUS_WIDTH-1:0]  dout_d;

    assign st_c[0]  = logic'(state_q);
    assign cnt_c[0] = cnt_q;
    assign cur_c[0] = cur_q;
    assign dval_v   = dval_c & {SEG_NUM{s1_valid_q}};

    for (genvar gi = 0; gi < SEG_NUM; gi++) begin : g_seg
        logic [EMPTY_W-1:0] empty_w;
        assign empty_w = s1_empty_q[gi*EMPTY_W +: EMPTY_W];

        crc_seg_classify u_cls (
            .state_i   (st_c[gi]),
            .sop_i     (s1_sop_q[gi]),
            .eop_i     (s1_eop_q[gi]),
            .state_o   (st_c[gi+1]),
            .sop_o     (sop_c[gi]),
            .eop_o     (eop_c[gi]),
            .dval_o    (dval_c[gi]),
            .inc_o     (inc_c[gi]),
            .err_sop_o (es_c[gi]),
            .err_eop_o (ee_c[gi])
        );

        assign cnt_c[gi+1] = cnt_c[gi] + PKT_NUM_W'(inc_c[gi]);
        assign cur_c[gi+1] = inc_c[gi] ? cnt_c[gi] : cur_c[gi];
        assign tag_d[gi*PKT_NUM_W +: PKT_NUM_W] = dval_c[gi] ? cur_c[gi+1] : '0;
        assign zero_d[gi*ZERO_NUM_W +: ZERO_NUM_W] =
            eop_c[gi] ? zero_num(gi, ZERO_NUM_W'(empty_w), SEG_NUM, SEG_B) : '0;

`ifdef CRC_SEG_PAD_ZERO_EN
        // Byte gj counts from the MSB end; trailing empty bytes of an eop go to 0.
        for (genvar gj = 0; gj < SEG_B; gj++) begin : g_byte
            assign dout_d[gi*BUS_WIDTH + BUS_WIDTH - 1 - 8*gj -: 8] =
                (dval_v[gi] && !(eop_c[gi] && ((gj + int'(empty_w)) >= SEG_B)))
                ? s1_data_q[gi*BUS_WIDTH + BUS_WIDTH - 1 - 8*gj -: 8] : 8'h00;
        end
`else
        assign dout_d[gi*BUS_WIDTH +: BUS_WIDTH] = s1_data_q[gi*BUS_WIDTH +: BUS_WIDTH];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q       <= 1'b0;
            s1_sop_q         <= '0;
            s1_eop_q         <= '0;
            s1_empty_q       <= '0;
            s1_data_q        <= '0;
            state_q          <= IDLE;
            cnt_q            <= '0;
            cur_q            <= '0;
            seg_sop_q        <= '0;
            seg_eop_q        <= '0;
            seg_dval_q       <= '0;
            seg_packet_num_q <= '0;
            seg_zero_num_q   <= '0;
            seg_dout_q       <= '0;
            err_sop_q        <= 1'b0;
            err_eop_q        <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            s1_sop_q   <= in_sop;
            s1_eop_q   <= in_eop;
            s1_empty_q <= in_empty;
            s1_data_q  <= in_data;
            seg_dout_q <= dout_d;
            if (s1_valid_q) begin
                state_q          <= walk_state_t'(st_c[SEG_NUM]);
                cnt_q            <= cnt_c[SEG_NUM];
                cur_q            <= cur_c[SEG_NUM];
                seg_sop_q        <= sop_c;
                seg_eop_q        <= eop_c;
                seg_dval_q       <= dval_c;
                seg_packet_num_q <= tag_d;
                seg_zero_num_q   <= zero_d;
                err_sop_q        <= |es_c;
                err_eop_q        <= |ee_c;
            end else begin
                seg_sop_q        <= '0;
                seg_eop_q        <= '0;
                seg_dval_q       <= '0;
                seg_packet_num_q <= '0;
                seg_zero_num_q   <= '0;
                err_sop_q        <= 1'b0;
                err_eop_q        <= 1'b0;
            end
        end
    end

    assign seg_sop        = seg_sop_q;
    assign seg_eop        = seg_eop_q;
    assign seg_dval       = seg_dval_q;
    assign seg_packet_num = seg_packet_num_q;
    assign seg_zero_num   = seg_zero_num_q;
    assign seg_dout       = seg_dout_q;
    assign err_sop        = err_sop_q;
    assign err_eop        = err_eop_q;

endmodule

// File: tb/tb_crc_seg_splitter.sv
// Directed bench for crc_seg_splitter (SEG_NUM=4, BUS_WIDTH=64, EMPTY_W=8);
// all expected values are hand-computed constants.
module tb_crc_seg_splitter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [3:0]   in_sop, in_eop;
    logic [31:0]  in_empty;
    logic [255:0] in_data;
    logic [3:0]   seg_sop, seg_eop, seg_dval;
    logic [15:0]  seg_packet_num;
    logic [47:0]  seg_zero_num;
    logic [255:0] seg_dout;
    logic         err_sop, err_eop;

    int n_checks = 0;
    int n_bad    = 0;

    logic [255:0] d1;
    logic [63:0]  exp_seg0, exp_seg1;

    always #5 clk = ~clk;

    crc_seg_splitter #(.SEG_NUM(4), .BUS_WIDTH(64), .EMPTY_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_empty       (in_empty),
        .in_data        (in_data),
        .seg_sop        (seg_sop),
        .seg_eop        (seg_eop),
        .seg_dval       (seg_dval),
        .seg_packet_num (seg_packet_num),
        .seg_zero_num   (seg_zero_num),
        .seg_dout       (seg_dout),
        .err_sop        (err_sop),
        .err_eop        (err_eop)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one valid beat, then idles; returns once that beat's outputs are visible.
    task automatic send(input logic [3:0] sop, input logic [3:0] eop,
                        input logic [31:0] empty, input logic [255:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = empty;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = '0;
        in_eop   = '0;
        in_empty = '0;
        @(posedge clk);
        #1;
        $display("beat sop=%b eop=%b empty=%h -> dval=%b sop=%b eop=%b tag=%h zero=%h es=%b ee=%b",
                 sop, eop, empty, seg_dval, seg_sop, seg_eop, seg_packet_num,
                 seg_zero_num, err_sop, err_eop);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sop   = '0;
        in_eop   = '0;
        in_empty = '0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dval", 64'(seg_dval), 64'h0);
        check_val("rst_sop_eop", 64'({seg_sop, seg_eop}), 64'h0);
        check_val("rst_tag", 64'(seg_packet_num), 64'h0);
        check_val("rst_zero", 64'(seg_zero_num), 64'h0);
        check_val("rst_dout0", seg_dout[63:0], 64'h0);
        check_val("rst_err", 64'({err_sop, err_eop}), 64'h0);
        rst = 1'b1;

        // Single-segment packet in segment 0
        d1 = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
              64'hD1D1D1D1D1D1D1D1, 64'h0123456789ABCDEF};
`ifdef CRC_SEG_PAD_ZERO_EN
        exp_seg0 = 64'h0123456789000000;
        exp_seg1 = 64'h0;
`else
        exp_seg0 = 64'h0123456789ABCDEF;
        exp_seg1 = 64'hD1D1D1D1D1D1D1D1;
`endif
        send(4'b0001, 4'b0001, 32'h0000_0003, d1);
        check_val("single_dval", 64'(seg_dval), 64'h1);
        check_val("single_sop", 64'(seg_sop), 64'h1);
        check_val("single_eop", 64'(seg_eop), 64'h1);
        check_val("single_tag", 64'(seg_packet_num), 64'h0);
        check_val("single_zero", 64'(seg_zero_num), 64'd27);
        check_val("single_dout0", seg_dout[63:0], exp_seg0);
        check_val("single_dout1", seg_dout[127:64], exp_seg1);
        @(posedge clk);
        #1;
        check_val("gap_dval", 64'(seg_dval), 64'h0);
        check_val("gap_err", 64'({err_sop, err_eop}), 64'h0);

        // Packet spanning two beats
        send(4'b0100, 4'b0000, 32'h0, '0);
        check_val("multi1_dval", 64'(seg_dval), 64'hC);
        check_val("multi1_sop", 64'(seg_sop), 64'h4);
        check_val("multi1_tag", 64'(seg_packet_num), 64'h1100);
        send(4'b0000, 4'b0010, 32'h0, '0);
        check_val("multi2_dval", 64'(seg_dval), 64'h3);
        check_val("multi2_eop", 64'(seg_eop), 64'h2);
        check_val("multi2_tag", 64'(seg_packet_num), 64'h0011);
        check_val("multi2_zero", 64'(seg_zero_num), 64'h10000);

        // Two packets in one beat
        send(4'b0101, 4'b1010, 32'h0500_0100, '0);
        check_val("two_dval", 64'(seg_dval), 64'hF);
        check_val("two_sop_eop", 64'({seg_sop, seg_eop}), 64'h5A);
        check_val("two_tag", 64'(seg_packet_num), 64'h3322);
        check_val("two_zero", 64'(seg_zero_num), 64'h005000011000);

        // eop with no open packet
        send(4'b0000, 4'b0001, 32'h0, '0);
        check_val("erreop_flag", 64'({err_sop, err_eop}), 64'h1);
        check_val("erreop_dval", 64'(seg_dval), 64'h0);

        // sop while a packet is open
        send(4'b0001, 4'b0000, 32'h0, '0);
        check_val("open_tag", 64'(seg_packet_num), 64'h4444);
        send(4'b0010, 4'b0000, 32'h0, '0);
        check_val("errsop_flag", 64'({err_sop, err_eop}), 64'h2);
        check_val("errsop_dval", 64'(seg_dval), 64'hF);
        check_val("errsop_tag", 64'(seg_packet_num), 64'h5554);
        send(4'b0000, 4'b0001, 32'h0, '0);
        check_val("close_tag", 64'(seg_packet_num), 64'h0005);
        check_val("close_zero", 64'(seg_zero_num), 64'd24);

        // Counter wraps 15 -> 0
        for (int i = 0; i < 11; i++) begin
            send(4'b0001, 4'b0001, 32'h0, '0);
            check_val($sformatf("wrap_tag%0d", i), 64'(seg_packet_num), 64'((6 + i) % 16));
        end

        // Reset in the middle of a packet
        send(4'b0001, 4'b0000, 32'h0, '0);
        check_val("pre_rst_tag", 64'(seg_packet_num), 64'h1111);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_rst_dval", 64'(seg_dval), 64'h0);
        check_val("mid_rst_tag", 64'(seg_packet_num), 64'h0);
        rst = 1'b1;
        send(4'b0000, 4'b0001, 32'h0, '0);
        check_val("post_rst_erreop", 64'({err_sop, err_eop}), 64'h1);
        check_val("post_rst_dval", 64'(seg_dval), 64'h0);
        send(4'b0001, 4'b0001, 32'h0, '0);
        check_val("post_rst_tag", 64'(seg_packet_num), 64'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
